decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter LOAD_USE_STALL, default 1: 1 enables load-use bubble insertion, 0 disables it.
REQ-002 SHALL have clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have id_valid, input, 1: instruction from the fetch stage is valid.
REQ-005 SHALL have id_instr, input, 32: instruction word.
REQ-006 SHALL have id_pc, input, 32: instruction address.
REQ-007 SHALL have id_ready, output, 1: stage accepts id_instr this cycle.
REQ-008 SHALL have rs1, rs2, output, 5 each: register-file read addresses, combinational from id_instr[19:15] and id_instr[24:20].
REQ-009 SHALL have rs1_data, rs2_data, input, 32 each: register-file read data, already write-bypassed.
REQ-010 SHALL have flush, input, 1: branch/jump redirect; kill the instruction in decode.
REQ-011 SHALL have ex_stall, input, 1: downstream cannot accept; hold outputs.
REQ-012 SHALL have ex_valid, ex_pc[31:0], ex_rs1_data[31:0], ex_rs2_data[31:0], ex_imm[31:0], ex_rs1[4:0], ex_rs2[4:0], ex_rd[4:0], ex_funct3[2:0], ex_alu_op[3:0], ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_illegal as registered outputs to execute.

Function
REQ-013 SHALL decode RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE (as NOP), SYSTEM (as NOP); any other opcode SHALL set ex_illegal=1 with reg_write, mem_read and mem_write forced to 0.
REQ-014 SHALL generate ex_imm by format: I sign-extended [31:20]; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; U {[31:12],12'b0}; J {[31],[19:12],[20],[30:21],0}; R 0.
REQ-015 SHALL force ex_reg_write=0 when rd=0.
REQ-016 SHALL compute load_use = LOAD_USE_STALL && id_valid && ex_valid && ex_mem_read && ex_rd!=0 && ((ex_rd==rs1 && rs1 used) || (ex_rd==rs2 && rs2 used)); rs1 is used by R, I, S, B, JALR and LOAD; rs2 by R, S and B.
REQ-017 SHALL drive id_ready = !ex_stall && !load_use, combinationally.
REQ-018 SHALL apply per-edge priority: flush -> ex_valid<=0, other outputs don't-care; else ex_stall -> hold all outputs; else load_use -> ex_valid<=0 (bubble), instruction retained upstream; else capture, with ex_valid<=id_valid.
REQ-019 SHALL have a latency of exactly one cycle from accepted id_instr to ex_* outputs.
REQ-020 SHALL ensure flush and load_use in the same cycle yield a bubble with no subsequent retry of the killed instruction by this stage.
REQ-021 SHALL keep the bubble at most one cycle per load-use pair, because the load leaves execute on the next edge.
REQ-022 SHALL ensure a bubble has ex_reg_write, ex_mem_read, ex_mem_write, ex_branch and ex_jump all 0.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously clear every ex_* output to 0.
REQ-024 SHALL make id_ready a function of inputs and register state only, giving 1 in reset when ex_stall=0.
REQ-025 SHALL resume from a mid-stream reset with ex_valid=0 and no retained instruction.

Structure
REQ-026 SHALL place opcode constants, the ALU_* op encodings (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B) and the immediate-format enum in the shared package rv_pkg.
REQ-027 SHALL place immediate generation in sub-module imm_gen (combinational, instr in, format in, imm out).

Verification
REQ-028 SHALL cover: ADDI x5,x0,-1 (0xFFF00293), rs1_data=0 -> next cycle ex_imm=0xFFFFFFFF, ex_rd=5, ex_alu_op=ALU_ADD, ex_alu_src=1, ex_reg_write=1.
REQ-029 SHALL cover: LW x6,0(x1) accepted, then ADD x7,x6,x2 -> id_ready=0 for one cycle, one bubble (ex_valid=0), then ADD issued with ex_rs1=6.
REQ-030 SHALL cover: LW x6 followed by ADD x7,x6,x2 with LOAD_USE_STALL=0 -> no bubble, id_ready=1.
REQ-031 SHALL cover: BEQ x1,x2,-4 (0xFE208EE3) -> ex_imm=0xFFFFFFFC, ex_branch=1, ex_reg_write=0.
REQ-032 SHALL cover: ex_stall=1 held for 3 cycles with changing inputs -> ex_* unchanged, id_ready=0; flush together with ex_stall -> ex_valid=0.
REQ-033 SHALL cover: opcode 0x7F -> ex_illegal=1, all write enables 0; rst_n pulsed low mid-stream -> ex_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: major opcodes, ALU operation encodings,
// immediate formats and the per-instruction control bundle.
package rv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_e;

    // IMM_R yields a zero immediate (register-register and illegal words).
    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_R = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        imm_fmt_e fmt;
        alu_op_e  alu_op;
        logic     alu_src;
        logic     mem_read;
        logic     mem_write;
        logic     reg_write;
        logic     branch;
        logic     jump;
        logic     illegal;
        logic     rs1_used;
        logic     rs2_used;
    } ctrl_t;

    // funct3 -> ALU op for OP and OP-IMM. instr[30] selects SUB only for
    // register-register forms (ADDI has no subtract variant) and SRA for both.
    function automatic alu_op_e alu_decode(input logic [2:0] funct3,
                                           input logic       alt,
                                           input logic       is_reg);
        alu_op_e op;
        case (funct3)
            3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: assembles the sign-extended immediate of an RV32I
// instruction word for the selected format. Purely combinational.
module imm_gen
    import rv_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [2:0]  fmt,
    output logic [31:0] imm
);

    // The opcode field never contributes to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // Format-directed bit gathering with sign extension from instr[31].
    always_comb begin
        imm = '0;
        case (imm_fmt_e'(fmt))
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes the instruction from fetch, detects load-use
// hazards against the instruction in execute and registers the decoded
// bundle for the execute stage. Flush beats stall beats load-use bubble.
module decode_stage
    import rv_pkg::*;
#(
    parameter bit LOAD_USE_STALL = 1'b1
)
(
    input  logic        clk,
    input  logic        rst_n,

    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc,
    output logic        id_ready,

    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,

    input  logic        flush,
    input  logic        ex_stall,

    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_funct3,
    output logic [3:0]  ex_alu_op,
    output logic        ex_alu_src,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_reg_write,
    output logic        ex_branch,
    output logic        ex_jump,
    output logic        ex_illegal
);

    logic [6:0]  opcode;
    logic [4:0]  rd_field;
    logic [2:0]  funct3;
    logic        funct7_alt;
    ctrl_t       ctrl;
    logic [31:0] imm;
    logic        hazard_rs1;
    logic        hazard_rs2;
    logic        load_use;

    assign opcode     = id_instr[6:0];
    assign rd_field   = id_instr[11:7];
    assign funct3     = id_instr[14:12];
    assign funct7_alt = id_instr[30];

    assign rs1 = id_instr[19:15];
    assign rs2 = id_instr[24:20];

    // Opcode decode into the control bundle; unknown opcodes become illegal
    // with every side effect suppressed.
    always_comb begin
        ctrl        = '0;
        ctrl.fmt    = IMM_R;
        ctrl.alu_op = ALU_ADD;
        case (opcode)
            OPC_LUI: begin
                ctrl.fmt       = IMM_U;
                ctrl.alu_op    = ALU_PASS_B;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl.fmt       = IMM_U;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            OPC_JAL: begin
                ctrl.fmt       = IMM_J;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
            end
            OPC_JALR: begin
                ctrl.fmt       = IMM_I;
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.rs1_used  = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.fmt      = IMM_B;
                ctrl.alu_op   = ALU_SUB;
                ctrl.branch   = 1'b1;
                ctrl.rs1_used = 1'b1;
                ctrl.rs2_used = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.fmt       = IMM_I;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.rs1_used  = 1'b1;
            end
            OPC_STORE: begin
                ctrl.fmt       = IMM_S;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.rs1_used  = 1'b1;
                ctrl.rs2_used  = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl.fmt       = IMM_I;
                ctrl.alu_op    = alu_decode(funct3, funct7_alt, 1'b0);
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.rs1_used  = 1'b1;
            end
            OPC_OP: begin
                ctrl.fmt       = IMM_R;
                ctrl.alu_op    = alu_decode(funct3, funct7_alt, 1'b1);
                ctrl.reg_write = 1'b1;
                ctrl.rs1_used  = 1'b1;
                ctrl.rs2_used  = 1'b1;
            end
            OPC_FENCE, OPC_SYSTEM: begin
                // Treated as NOPs: decoded I-immediate, no side effects.
                ctrl.fmt = IMM_I;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
        if (rd_field == 5'd0) begin
            ctrl.reg_write = 1'b0;
        end
    end

    imm_gen u_imm_gen (
        .instr (id_instr),
        .fmt   (ctrl.fmt),
        .imm   (imm)
    );

    // Only a load still in execute can produce this hazard; its data is not
    // available for bypass until it leaves, so one bubble always suffices.
    assign hazard_rs1 = ctrl.rs1_used && (ex_rd == rs1);
    assign hazard_rs2 = ctrl.rs2_used && (ex_rd == rs2);
    assign load_use   = LOAD_USE_STALL && id_valid && ex_valid && ex_mem_read &&
                        (ex_rd != 5'd0) && (hazard_rs1 || hazard_rs2);

    assign id_ready = !ex_stall && !load_use;

    // Pipeline register toward execute: flush, then stall hold, then bubble,
    // else capture. Control bits are qualified by id_valid so that an empty
    // slot never carries side effects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_funct3    <= '0;
            ex_alu_op    <= '0;
            ex_alu_src   <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_branch    <= 1'b0;
            ex_jump      <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (!ex_stall) begin
            if (load_use) begin
                ex_valid     <= 1'b0;
                ex_mem_read  <= 1'b0;
                ex_mem_write <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_branch    <= 1'b0;
                ex_jump      <= 1'b0;
                ex_illegal   <= 1'b0;
            end else begin
                ex_valid     <= id_valid;
                ex_pc        <= id_pc;
                ex_rs1_data  <= rs1_data;
                ex_rs2_data  <= rs2_data;
                ex_imm       <= imm;
                ex_rs1       <= rs1;
                ex_rs2       <= rs2;
                ex_rd        <= rd_field;
                ex_funct3    <= funct3;
                ex_alu_op    <= ctrl.alu_op;
                ex_alu_src   <= ctrl.alu_src;
                ex_mem_read  <= id_valid && ctrl.mem_read;
                ex_mem_write <= id_valid && ctrl.mem_write;
                ex_reg_write <= id_valid && ctrl.reg_write;
                ex_branch    <= id_valid && ctrl.branch;
                ex_jump      <= id_valid && ctrl.jump;
                ex_illegal   <= id_valid && ctrl.illegal;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: one instance with load-use stalling, one without,
// both fed the same stimulus and each tracked by an instruction-level model.
module tb_decode_stage;
    import rv_pkg::*;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [3:0]  op;
        logic        src;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        br;
        logic        jp;
        logic        ill;
    } ex_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  op;
        logic [6:0]  ctl; // {src, rw, mr, mw, br, jp, ill}
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        ex_stall;

    logic        id_ready_w [2];
    logic [4:0]  rs1_w [2];
    logic [4:0]  rs2_w [2];
    logic        ex_valid_w [2];
    logic [31:0] ex_pc_w [2];
    logic [31:0] ex_rs1_data_w [2];
    logic [31:0] ex_rs2_data_w [2];
    logic [31:0] ex_imm_w [2];
    logic [4:0]  ex_rs1_w [2];
    logic [4:0]  ex_rs2_w [2];
    logic [4:0]  ex_rd_w [2];
    logic [2:0]  ex_funct3_w [2];
    logic [3:0]  ex_alu_op_w [2];
    logic        ex_alu_src_w [2];
    logic        ex_mem_read_w [2];
    logic        ex_mem_write_w [2];
    logic        ex_reg_write_w [2];
    logic        ex_branch_w [2];
    logic        ex_jump_w [2];
    logic        ex_illegal_w [2];
    ex_t         obs [2];

    always #5 clk = ~clk;

    // Instance 0 stalls on load-use, instance 1 does not.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        decode_stage #(.LOAD_USE_STALL(g == 0)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .id_valid     (id_valid),
            .id_instr     (id_instr),
            .id_pc        (id_pc),
            .id_ready     (id_ready_w[g]),
            .rs1          (rs1_w[g]),
            .rs2          (rs2_w[g]),
            .rs1_data     (rs1_data),
            .rs2_data     (rs2_data),
            .flush        (flush),
            .ex_stall     (ex_stall),
            .ex_valid     (ex_valid_w[g]),
            .ex_pc        (ex_pc_w[g]),
            .ex_rs1_data  (ex_rs1_data_w[g]),
            .ex_rs2_data  (ex_rs2_data_w[g]),
            .ex_imm       (ex_imm_w[g]),
            .ex_rs1       (ex_rs1_w[g]),
            .ex_rs2       (ex_rs2_w[g]),
            .ex_rd        (ex_rd_w[g]),
            .ex_funct3    (ex_funct3_w[g]),
            .ex_alu_op    (ex_alu_op_w[g]),
            .ex_alu_src   (ex_alu_src_w[g]),
            .ex_mem_read  (ex_mem_read_w[g]),
            .ex_mem_write (ex_mem_write_w[g]),
            .ex_reg_write (ex_reg_write_w[g]),
            .ex_branch    (ex_branch_w[g]),
            .ex_jump      (ex_jump_w[g]),
            .ex_illegal   (ex_illegal_w[g])
        );
        assign obs[g] = {ex_valid_w[g], ex_pc_w[g], ex_rs1_data_w[g], ex_rs2_data_w[g],
                         ex_imm_w[g], ex_rs1_w[g], ex_rs2_w[g], ex_rd_w[g], ex_funct3_w[g],
                         ex_alu_op_w[g], ex_alu_src_w[g], ex_mem_read_w[g], ex_mem_write_w[g],
                         ex_reg_write_w[g], ex_branch_w[g], ex_jump_w[g], ex_illegal_w[g]};
    end

    int  n_checks = 0;
    int  n_fail   = 0;
    ex_t mdl [2];
    int  lvl [2];   // 0: only valid known, 1: valid + side-effect bits, 2: everything

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode straight from the RV32I field definitions.
    function automatic ex_t decode_ref(input logic [31:0] i, input logic [31:0] pc,
                                       input logic [31:0] d1, input logic [31:0] d2);
        ex_t        e;
        int         v_i, v_s, v_b, v_j, v_u;
        logic [3:0] f3map [8];
        f3map = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        v_i = int'(i[31:20]) - (i[31] ? 4096 : 0);
        v_s = int'(i[31:25]) * 32 + int'(i[11:7]) - (i[31] ? 4096 : 0);
        v_b = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2 - (i[31] ? 4096 : 0);
        v_j = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2 - (i[31] ? 1048576 : 0);
        v_u = int'(i[31:12]) * 4096;
        e       = '0;
        e.valid = 1'b1;
        e.pc    = pc;
        e.d1    = d1;
        e.d2    = d2;
        e.rs1   = i[19:15];
        e.rs2   = i[24:20];
        e.rd    = i[11:7];
        e.f3    = i[14:12];
        e.op    = ALU_ADD;
        case (i[6:0])
            OPC_LUI:    begin e.imm = v_u; e.op = ALU_PASS_B; e.src = 1; e.rw = 1; end
            OPC_AUIPC:  begin e.imm = v_u; e.src = 1; e.rw = 1; end
            OPC_JAL:    begin e.imm = v_j; e.src = 1; e.rw = 1; e.jp = 1; end
            OPC_JALR:   begin e.imm = v_i; e.src = 1; e.rw = 1; e.jp = 1; end
            OPC_BRANCH: begin e.imm = v_b; e.op = ALU_SUB; e.br = 1; end
            OPC_LOAD:   begin e.imm = v_i; e.src = 1; e.rw = 1; e.mr = 1; end
            OPC_STORE:  begin e.imm = v_s; e.src = 1; e.mw = 1; end
            OPC_OP_IMM: begin
                e.imm = v_i; e.src = 1; e.rw = 1;
                e.op  = f3map[i[14:12]];
                if (i[14:12] == 3'd5 && i[30]) e.op = ALU_SRA;
            end
            OPC_OP: begin
                e.rw = 1;
                e.op = f3map[i[14:12]];
                if (i[14:12] == 3'd5 && i[30]) e.op = ALU_SRA;
                if (i[14:12] == 3'd0 && i[30]) e.op = ALU_SUB;
            end
            OPC_FENCE, OPC_SYSTEM: e.imm = v_i;
            default: e.ill = 1;
        endcase
        if (e.rd == 5'd0) e.rw = 0;
        return e;
    endfunction

    function automatic bit ref_load_use(input int k);
        logic [6:0] o;
        bit         u1, u2;
        o  = id_instr[6:0];
        u1 = o inside {OPC_OP, OPC_OP_IMM, OPC_STORE, OPC_BRANCH, OPC_JALR, OPC_LOAD};
        u2 = o inside {OPC_OP, OPC_STORE, OPC_BRANCH};
        if (k != 0 || !id_valid || !mdl[k].valid || !mdl[k].mr || mdl[k].rd == 5'd0) return 1'b0;
        return (u1 && mdl[k].rd == id_instr[19:15]) || (u2 && mdl[k].rd == id_instr[24:20]);
    endfunction

    task automatic check_ex(input int k);
        ex_t o;
        o = obs[k];
        if (lvl[k] == 2) begin
            chk($sformatf("ex_bundle[%0d]", k), o, mdl[k]);
        end else begin
            chk($sformatf("ex_valid[%0d]", k), o.valid, mdl[k].valid);
            if (lvl[k] == 1)
                chk($sformatf("bubble_ctl[%0d]", k), {o.rw, o.mr, o.mw, o.br, o.jp}, 5'b0);
        end
    endtask

    // One clock: check combinational outputs, clock, advance models, check ex_*.
    task automatic step();
        bit lu [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            lu[k] = ref_load_use(k);
            chk($sformatf("id_ready[%0d]", k), id_ready_w[k], !ex_stall && !lu[k]);
        end
        chk("rs1_addr", rs1_w[0], id_instr[19:15]);
        chk("rs2_addr", rs2_w[0], id_instr[24:20]);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (flush) begin
                mdl[k].valid = 0; lvl[k] = 0;
            end else if (ex_stall) begin
                // hold
            end else if (lu[k]) begin
                mdl[k].valid = 0; lvl[k] = 1;
            end else if (id_valid) begin
                mdl[k] = decode_ref(id_instr, id_pc, rs1_data, rs2_data); lvl[k] = 2;
            end else begin
                mdl[k].valid = 0; lvl[k] = 0;
            end
            check_ex(k);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr);
        id_valid = v;
        id_instr = instr;
        id_pc    = id_pc + 32'd4;
        rs1_data = $urandom;
        rs2_data = $urandom;
    endtask

    localparam logic [31:0] I_LW  = 32'h0000A303; // lw   x6,0(x1)
    localparam logic [31:0] I_ADD = 32'h002303B3; // add  x7,x6,x2
    localparam logic [31:0] I_ADDI = 32'hFFF00293; // addi x5,x0,-1

    vec_t       tbl [9];
    ex_t        e_hold;
    logic [6:0] ops [12];

    initial begin
        tbl[0] = '{32'hFFF00293, 32'hFFFFFFFF, 5'd5,  ALU_ADD,    7'b1100000}; // addi x5,x0,-1
        tbl[1] = '{32'hFE208EE3, 32'hFFFFFFFC, 5'd29, ALU_SUB,    7'b0000100}; // beq x1,x2,-4
        tbl[2] = '{32'h0000037F, 32'h00000000, 5'd6,  ALU_ADD,    7'b0000001}; // opcode 0x7F
        tbl[3] = '{32'h123450B7, 32'h12345000, 5'd1,  ALU_PASS_B, 7'b1100000}; // lui x1,0x12345
        tbl[4] = '{32'h0020A423, 32'h00000008, 5'd8,  ALU_ADD,    7'b1001000}; // sw x2,8(x1)
        tbl[5] = '{32'h0000A303, 32'h00000000, 5'd6,  ALU_ADD,    7'b1110000}; // lw x6,0(x1)
        tbl[6] = '{32'h402081B3, 32'h00000000, 5'd3,  ALU_SUB,    7'b0100000}; // sub x3,x1,x2
        tbl[7] = '{32'h00000013, 32'h00000000, 5'd0,  ALU_ADD,    7'b1000000}; // addi x0,x0,0
        tbl[8] = '{32'h008000EF, 32'h00000008, 5'd1,  ALU_ADD,    7'b1100010}; // jal x1,+8
        ops = '{OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE,
                OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM, 7'h7F};

        // Reset state
        rst_n = 0; id_valid = 0; id_instr = '0; id_pc = 32'h1000;
        rs1_data = '0; rs2_data = '0; flush = 0; ex_stall = 0;
        #12;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset_outputs[%0d]", k), obs[k], '0);
            chk($sformatf("reset_ready[%0d]", k), id_ready_w[k], 1'b1);
        end
        ex_stall = 1; #1;
        chk("reset_ready_stalled", id_ready_w[0], 1'b0);
        ex_stall = 0;
        @(posedge clk); #1;
        rst_n = 1;
        mdl[0] = '0; mdl[1] = '0; lvl[0] = 2; lvl[1] = 2;

        // Table of single-instruction decodes
        for (int n = 0; n < 9; n++) begin
            drive(1'b1, tbl[n].instr);
            step();
            chk($sformatf("tbl%0d_valid", n), ex_valid_w[0], 1'b1);
            chk($sformatf("tbl%0d_imm", n), ex_imm_w[0], tbl[n].imm);
            chk($sformatf("tbl%0d_rd", n), ex_rd_w[0], tbl[n].rd);
            chk($sformatf("tbl%0d_alu_op", n), ex_alu_op_w[0], tbl[n].op);
            chk($sformatf("tbl%0d_ctl", n),
                {ex_alu_src_w[0], ex_reg_write_w[0], ex_mem_read_w[0], ex_mem_write_w[0],
                 ex_branch_w[0], ex_jump_w[0], ex_illegal_w[0]}, tbl[n].ctl);
        end

        // Load-use: one bubble with stalling, none without
        drive(1'b1, I_LW);
        step();
        drive(1'b1, I_ADD);
        #1;
        chk("lu_ready_stall", id_ready_w[0], 1'b0);
        chk("lu_ready_nostall", id_ready_w[1], 1'b1);
        step();
        chk("lu_bubble_valid", ex_valid_w[0], 1'b0);
        chk("lu_bubble_ctl", {ex_reg_write_w[0], ex_mem_read_w[0], ex_mem_write_w[0],
                              ex_branch_w[0], ex_jump_w[0]}, 5'b0);
        chk("nolu_issue_valid", ex_valid_w[1], 1'b1);
        chk("nolu_issue_rs1", ex_rs1_w[1], 5'd6);
        #1;
        chk("lu_ready_after_bubble", id_ready_w[0], 1'b1);
        step();
        chk("lu_issue_valid", ex_valid_w[0], 1'b1);
        chk("lu_issue_rs1", ex_rs1_w[0], 5'd6);
        chk("lu_issue_rd", ex_rd_w[0], 5'd7);

        // Stall holds outputs for three cycles, then flush wins over stall
        drive(1'b1, I_ADDI);
        e_hold = decode_ref(I_ADDI, id_pc, rs1_data, rs2_data);
        step();
        ex_stall = 1;
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, tbl[(n + 3) % 9].instr);
            #1;
            chk("stall_ready", id_ready_w[0], 1'b0);
            step();
            chk("stall_hold", obs[0], e_hold);
        end
        flush = 1;
        step();
        chk("flush_over_stall", ex_valid_w[0], 1'b0);
        flush = 0; ex_stall = 0;

        // Flush coinciding with load-use: bubble, and nothing retried afterwards
        drive(1'b1, I_LW);
        step();
        drive(1'b1, I_ADD);
        flush = 1;
        step();
        chk("flush_lu_valid", ex_valid_w[0], 1'b0);
        flush = 0;
        drive(1'b0, I_ADD);
        step();
        chk("flush_lu_no_retry", ex_valid_w[0], 1'b0);

        // Mid-stream asynchronous reset
        drive(1'b1, I_ADDI);
        step();
        #2;
        rst_n = 0;
        #1;
        chk("async_reset_valid", ex_valid_w[0], 1'b0);
        chk("async_reset_all", obs[0], '0);
        chk("async_reset_ready", id_ready_w[0], 1'b1);
        mdl[0] = '0; mdl[1] = '0; lvl[0] = 2; lvl[1] = 2;
        drive(1'b0, I_ADDI);
        @(posedge clk); #1;
        rst_n = 1;
        step();
        chk("resume_valid", ex_valid_w[0], 1'b0);

        // Randomized stream against the model; small register range to hit hazards
        for (int n = 0; n < 400; n++) begin
            logic [31:0] w;
            if (!(id_ready_w[0] === 1'b0 && $urandom_range(0, 1) == 1)) begin
                w        = $urandom;
                w[6:0]   = ops[$urandom_range(0, 11)];
                w[11:7]  = 5'($urandom_range(0, 3));
                w[19:15] = 5'($urandom_range(0, 3));
                w[24:20] = 5'($urandom_range(0, 3));
                drive($urandom_range(0, 9) != 0, w);
            end
            flush    = ($urandom_range(0, 19) == 0);
            ex_stall = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
